// File: rtl/router_pkg.sv
// Shared constants and configuration helpers for the router output-side blocks.
package router_pkg;

  localparam int ROUTER_NUM_CH      = 3;
  localparam int ROUTER_ADDR_W      = 2;
  localparam int ROUTER_CNT_W       = 5;
  localparam int ROUTER_DEF_TIMEOUT = 30;

  // True when an addr_w-bit header field can name every one of num_ch channels.
  function automatic bit addr_fits(input int addr_w, input int num_ch);
    return (1 << addr_w) >= num_ch;
  endfunction

endpackage

// File: rtl/router_sft_rst_timer.sv
// Single-channel FIFO read-timeout counter: one-cycle soft_reset pulse plus a
// sticky write-1-clear status bit.
module router_sft_rst_timer #(
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cnt_clr,
  input  logic             empty,
  input  logic             read_enb,
  input  logic             status_clr,
  input  logic [CNT_W-1:0] timeout_reg,
  output logic             soft_reset,
  output logic             sft_rst_status
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             pulse_nxt;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cnt_nxt   = cnt + CNT_W'(1);
    pulse_nxt = 1'b0;
    if (cnt_clr || empty || read_enb) begin
      cnt_nxt = '0;
    end else if (cnt == timeout_reg - CNT_W'(1)) begin
      // Compare precedes the increment, so the counter never wraps.
      cnt_nxt   = '0;
      pulse_nxt = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt            <= '0;
      soft_reset     <= 1'b0;
      sft_rst_status <= 1'b0;
    end else begin
      cnt            <= cnt_nxt;
      soft_reset     <= pulse_nxt;
      // Setting wins over a same-edge clear.
      sft_rst_status <= pulse_nxt | (sft_rst_status & ~status_clr);
    end
  end

endmodule

// File: rtl/router_sync_n.sv
// N-channel synchroniser between the router FSM and the output FIFOs: address
// capture/decode, full-flag mux, valid generation and per-channel read timeouts.
module router_sync_n
  import router_pkg::*;
#(
  parameter int NUM_CH      = ROUTER_NUM_CH,
  parameter int ADDR_W      = ROUTER_ADDR_W,
  parameter int CNT_W       = ROUTER_CNT_W,
  parameter int DEF_TIMEOUT = ROUTER_DEF_TIMEOUT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              detect_add,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              write_enb_reg,
  input  logic [NUM_CH-1:0] read_enb,
  input  logic [NUM_CH-1:0] empty,
  input  logic [NUM_CH-1:0] full,
  input  logic              timeout_ld,
  input  logic [CNT_W-1:0]  timeout_val,
  input  logic [NUM_CH-1:0] status_clr,
  output logic [NUM_CH-1:0] write_enb,
  output logic              fifo_full,
  output logic              addr_err,
  output logic [NUM_CH-1:0] vld_out,
  output logic [NUM_CH-1:0] soft_reset,
  output logic [NUM_CH-1:0] sft_rst_status
);

  if (!addr_fits(ADDR_W, NUM_CH)) begin : g_bad_cfg
    $error("router_sync_n: ADDR_W too narrow for NUM_CH");
  end

  logic [ADDR_W-1:0] fifo_addr;
  logic [CNT_W-1:0]  timeout_reg;
  logic              cnt_clr;

  always_ff @(posedge clock) begin
    if (reset) begin
      fifo_addr   <= '0;
      addr_err    <= 1'b0;
      timeout_reg <= CNT_W'(DEF_TIMEOUT);
    end else begin
      if (detect_add) begin
        fifo_addr <= data_in;
        addr_err  <= int'(data_in) >= NUM_CH;
      end
      if (timeout_ld) begin
        timeout_reg <= timeout_val;
      end
    end
  end

  // Loop compare keeps an out-of-range address from ever indexing the vectors.
  always_comb begin
    write_enb = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!addr_err && fifo_addr == ADDR_W'(i)) begin
        write_enb[i] = write_enb_reg;
        fifo_full    = full[i];
      end
    end
  end

  assign vld_out = ~empty;
  assign cnt_clr = timeout_ld || (timeout_reg == '0);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_timer
    router_sft_rst_timer #(
      .CNT_W (CNT_W)
    ) u_timer (
      .clock          (clock),
      .reset          (reset),
      .cnt_clr        (cnt_clr),
      .empty          (empty[g]),
      .read_enb       (read_enb[g]),
      .status_clr     (status_clr[g]),
      .timeout_reg    (timeout_reg),
      .soft_reset     (soft_reset[g]),
      .sft_rst_status (sft_rst_status[g])
    );
  end

endmodule

// File: tb/tb_router_sync_n.sv
// Self-checking bench for router_sync_n: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_router_sync_n;
  import router_pkg::*;

  localparam int NUM_CH = ROUTER_NUM_CH;
  localparam int ADDR_W = ROUTER_ADDR_W;
  localparam int CNT_W  = ROUTER_CNT_W;
  localparam int DEF_TO = ROUTER_DEF_TIMEOUT;

  logic              clock = 1'b0;
  logic              reset;
  logic              detect_add;
  logic [ADDR_W-1:0] data_in;
  logic              write_enb_reg;
  logic [NUM_CH-1:0] read_enb;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] full;
  logic              timeout_ld;
  logic [CNT_W-1:0]  timeout_val;
  logic [NUM_CH-1:0] status_clr;
  logic [NUM_CH-1:0] write_enb;
  logic              fifo_full;
  logic              addr_err;
  logic [NUM_CH-1:0] vld_out;
  logic [NUM_CH-1:0] soft_reset;
  logic [NUM_CH-1:0] sft_rst_status;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  router_sync_n dut (
    .clock          (clock),
    .reset          (reset),
    .detect_add     (detect_add),
    .data_in        (data_in),
    .write_enb_reg  (write_enb_reg),
    .read_enb       (read_enb),
    .empty          (empty),
    .full           (full),
    .timeout_ld     (timeout_ld),
    .timeout_val    (timeout_val),
    .status_clr     (status_clr),
    .write_enb      (write_enb),
    .fifo_full      (fifo_full),
    .addr_err       (addr_err),
    .vld_out        (vld_out),
    .soft_reset     (soft_reset),
    .sft_rst_status (sft_rst_status)
  );

  // Behavioural model: counts consecutive stalled edges (valid, unread) per channel.
  int                m_addr;
  bit                m_err;
  int                m_tout;
  int                m_run [NUM_CH];
  logic [NUM_CH-1:0] m_pulse;
  logic [NUM_CH-1:0] m_stat;

  always @(posedge clock) begin
    if (reset) begin
      m_addr  <= 0;
      m_err   <= 1'b0;
      m_tout  <= DEF_TO;
      m_pulse <= '0;
      m_stat  <= '0;
      for (int i = 0; i < NUM_CH; i++) m_run[i] <= 0;
    end else begin
      if (detect_add) begin
        m_addr <= int'(data_in);
        m_err  <= int'(data_in) >= NUM_CH;
      end
      if (timeout_ld) m_tout <= int'(timeout_val);
      for (int i = 0; i < NUM_CH; i++) begin
        if (timeout_ld || m_tout == 0 || empty[i] || read_enb[i]) begin
          m_run[i]   <= 0;
          m_pulse[i] <= 1'b0;
          m_stat[i]  <= m_stat[i] & ~status_clr[i];
        end else if (m_run[i] + 1 >= m_tout) begin
          m_run[i]   <= 0;
          m_pulse[i] <= 1'b1;
          m_stat[i]  <= 1'b1;
        end else begin
          m_run[i]   <= m_run[i] + 1;
          m_pulse[i] <= 1'b0;
          m_stat[i]  <= m_stat[i] & ~status_clr[i];
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    detect_add    = 1'b0;
    data_in       = '0;
    write_enb_reg = 1'b0;
    read_enb      = '0;
    empty         = '1;
    full          = '0;
    timeout_ld    = 1'b0;
    timeout_val   = '0;
    status_clr    = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    checks++;
    if (soft_reset !== '0 || sft_rst_status !== '0 || addr_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got sr=%b st=%b err=%b exp all zero", soft_reset, sft_rst_status, addr_err);
    end
    write_enb_reg = 1'b1;
    full          = 3'b001;
    #1;
    checks++;
    if (write_enb !== 3'b001 || fifo_full !== 1'b1 || vld_out !== 3'b000) begin
      errors++;
      $display("FAIL reset_addr got we=%b ff=%b vld=%b exp we=001 ff=1 vld=000", write_enb, fifo_full, vld_out);
    end
    write_enb_reg = 1'b0;
    full          = '0;
    reset         = 1'b0;
    tick();
  endtask

  task automatic test_addr_decode();
    detect_add = 1'b1;
    data_in    = 2'd2;
    tick();
    detect_add    = 1'b0;
    write_enb_reg = 1'b1;
    full          = 3'b100;
    #1;
    checks++;
    if (write_enb !== 3'b100 || addr_err !== 1'b0 || fifo_full !== 1'b1) begin
      errors++;
      $display("FAIL addr2 got we=%b err=%b ff=%b exp we=100 err=0 ff=1", write_enb, addr_err, fifo_full);
    end
    full = 3'b011;
    #1;
    checks++;
    if (fifo_full !== 1'b0) begin
      errors++;
      $display("FAIL addr2_notfull got ff=%b exp 0", fifo_full);
    end
    detect_add = 1'b1;
    data_in    = 2'd3;
    tick();
    detect_add = 1'b0;
    full       = 3'b111;
    #1;
    checks++;
    if (addr_err !== 1'b1 || write_enb !== 3'b000 || fifo_full !== 1'b0) begin
      errors++;
      $display("FAIL addr3_err got err=%b we=%b ff=%b exp err=1 we=000 ff=0", addr_err, write_enb, fifo_full);
    end
    detect_add = 1'b1;
    data_in    = 2'd0;
    tick();
    detect_add = 1'b0;
    #1;
    checks++;
    if (addr_err !== 1'b0 || write_enb !== 3'b001 || fifo_full !== 1'b1) begin
      errors++;
      $display("FAIL addr0 got err=%b we=%b ff=%b exp err=0 we=001 ff=1", addr_err, write_enb, fifo_full);
    end
    write_enb_reg = 1'b0;
    #1;
    checks++;
    if (write_enb !== 3'b000) begin
      errors++;
      $display("FAIL addr_noqual got we=%b exp 000", write_enb);
    end
    full = '0;
  endtask

  task automatic test_timeout_default();
    int bad;
    empty = 3'b101;
    bad   = 0;
    for (int k = 1; k <= 62; k++) begin
      tick();
      if (soft_reset !== {1'b0, (k == 30 || k == 60), 1'b0}) bad++;
      if (k == 30) begin
        checks++;
        if (sft_rst_status !== 3'b010 || vld_out !== 3'b010) begin
          errors++;
          $display("FAIL to_default_status got st=%b vld=%b exp st=010 vld=010", sft_rst_status, vld_out);
        end
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL to_default_pulses got %0d wrong cycles exp 0", bad);
    end
    // Restart: 62 mod 30 leaves count 2; clear with a read first.
    read_enb = 3'b010;
    tick();
    read_enb = '0;
    bad      = 0;
    for (int k = 1; k <= 47; k++) begin
      read_enb = (k == 15) ? 3'b010 : 3'b000;
      tick();
      if (soft_reset[1] !== (k == 45)) bad++;
    end
    read_enb = '0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL to_read_restart got %0d wrong cycles exp 0", bad);
    end
    empty = '1;
    tick();
  endtask

  task automatic test_timeout_load();
    int bad;
    empty = 3'b110;
    bad   = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (soft_reset !== '0) bad++;
    end
    timeout_ld  = 1'b1;
    timeout_val = 5'd4;
    tick();
    timeout_ld = 1'b0;
    if (soft_reset !== '0) bad++;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (soft_reset !== {2'b00, (k == 4 || k == 8)}) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL to_load4 got %0d wrong cycles exp 0", bad);
    end
    timeout_ld  = 1'b1;
    timeout_val = '0;
    tick();
    timeout_ld = 1'b0;
    empty      = '0;
    bad        = 0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (soft_reset !== '0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL to_disabled got %0d pulsing cycles exp 0", bad);
    end
    empty = '1;
  endtask

  task automatic test_status_clr();
    status_clr = 3'b001;
    tick();
    status_clr = '0;
    checks++;
    if (sft_rst_status[0] !== 1'b0) begin
      errors++;
      $display("FAIL st_pre_clear got %b exp 0", sft_rst_status[0]);
    end
    timeout_ld  = 1'b1;
    timeout_val = 5'd4;
    tick();
    timeout_ld = 1'b0;
    empty      = 3'b110;
    tick();
    tick();
    tick();
    status_clr = 3'b001;
    tick();
    checks++;
    if (soft_reset[0] !== 1'b1 || sft_rst_status[0] !== 1'b1) begin
      errors++;
      $display("FAIL st_set_wins got sr=%b st=%b exp sr=1 st=1", soft_reset[0], sft_rst_status[0]);
    end
    empty = '1;
    tick();
    checks++;
    if (soft_reset[0] !== 1'b0 || sft_rst_status[0] !== 1'b0) begin
      errors++;
      $display("FAIL st_clear got sr=%b st=%b exp sr=0 st=0", soft_reset[0], sft_rst_status[0]);
    end
    status_clr = '0;
  endtask

  task automatic test_reset_mid();
    int bad;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    empty = 3'b011;
    for (int k = 1; k <= 25; k++) tick();
    reset         = 1'b1;
    detect_add    = 1'b1;
    data_in       = 2'd1;
    write_enb_reg = 1'b1;
    tick();
    checks++;
    if (soft_reset !== '0 || sft_rst_status !== '0 || addr_err !== 1'b0 ||
        write_enb !== 3'b001 || vld_out !== 3'b100) begin
      errors++;
      $display("FAIL reset_mid got sr=%b st=%b err=%b we=%b vld=%b exp 000 000 0 001 100",
               soft_reset, sft_rst_status, addr_err, write_enb, vld_out);
    end
    reset         = 1'b0;
    detect_add    = 1'b0;
    write_enb_reg = 1'b0;
    bad           = 0;
    for (int k = 1; k <= 31; k++) begin
      tick();
      if (soft_reset !== {(k == 30), 2'b00}) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_full_stall got %0d wrong cycles exp 0", bad);
    end
    empty = '1;
  endtask

  task automatic test_random();
    logic [NUM_CH-1:0] exp_we;
    logic              exp_ff;
    for (int n = 0; n < 600; n++) begin
      reset         = ($urandom_range(0, 149) == 0);
      detect_add    = ($urandom_range(0, 4) == 0);
      data_in       = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
      write_enb_reg = 1'($urandom_range(0, 1));
      full          = NUM_CH'($urandom_range(0, (1 << NUM_CH) - 1));
      timeout_ld    = ($urandom_range(0, 39) == 0);
      timeout_val   = CNT_W'($urandom_range(0, 6));
      for (int i = 0; i < NUM_CH; i++) begin
        empty[i]      = ($urandom_range(0, 5) == 0);
        read_enb[i]   = ($urandom_range(0, 9) == 0);
        status_clr[i] = ($urandom_range(0, 5) == 0);
      end
      #1;
      exp_we = '0;
      exp_ff = 1'b0;
      if (!m_err) begin
        exp_we[m_addr] = write_enb_reg;
        exp_ff         = full[m_addr];
      end
      checks++;
      if (write_enb !== exp_we || fifo_full !== exp_ff || addr_err !== m_err ||
          vld_out !== ~empty || soft_reset !== m_pulse || sft_rst_status !== m_stat) begin
        errors++;
        $display("FAIL rand_%0d got we=%b ff=%b err=%b vld=%b sr=%b st=%b exp we=%b ff=%b err=%b vld=%b sr=%b st=%b",
                 n, write_enb, fifo_full, addr_err, vld_out, soft_reset, sft_rst_status,
                 exp_we, exp_ff, m_err, ~empty, m_pulse, m_stat);
      end
      tick();
    end
    idle_inputs();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_addr_decode();
    test_timeout_default();
    test_timeout_load();
    test_status_clr();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/router_sync_n.md
Name: router_sync_n

Overview:
- Parametrised N-channel synchroniser between the router FSM/register stage and N output FIFOs.
- Captures the destination address from the header and decodes per-FIFO write enables. Muxes the selected FIFO's full flag and drives per-channel valid.
- Generates per-channel soft-reset pulses when a FIFO is not read within a runtime-programmable timeout.
- Adds behaviour the 3-channel version lacks: address-error detection, a programmable/disable-able timeout, and sticky timeout status with write-1-clear.

Parameters:
- NUM_CH, 3, number of output channels/FIFOs (2..16)
- ADDR_W, 2, width of the header address field; must satisfy 2**ADDR_W >= NUM_CH
- CNT_W, 5, width of the timeout counters and the timeout register
- DEF_TIMEOUT, 30, timeout value after reset (1 .. 2**CNT_W-1)

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high reset
- detect_add  in  1  header-address capture strobe
- data_in  in  ADDR_W  destination address (header low bits)
- write_enb_reg  in  1  FSM write qualifier
- read_enb  in  NUM_CH  per-FIFO read enables
- empty  in  NUM_CH  per-FIFO empty flags
- full  in  NUM_CH  per-FIFO full flags
- timeout_ld  in  1  load strobe for the timeout register
- timeout_val  in  CNT_W  new timeout value; 0 = soft-reset generation disabled
- status_clr  in  NUM_CH  write-1-clear for sticky status
- write_enb  out  NUM_CH  one-hot FIFO write enable
- fifo_full  out  1  full flag of the addressed FIFO
- addr_err  out  1  captured address is out of range
- vld_out  out  NUM_CH  per-channel data valid
- soft_reset  out  NUM_CH  one-cycle per-channel FIFO soft reset
- sft_rst_status  out  NUM_CH  sticky "timeout occurred"

Behaviour:
- Reset (sync, active-high) clears the following, taking priority over all else, including mid-count or mid-load:
  - fifo_addr=0, addr_err=0
  - soft_reset=0, sft_rst_status=0
  - all counters=0
  - timeout_reg=DEF_TIMEOUT
- Address capture, registered:
  - If detect_add: fifo_addr<=data_in; addr_err<=(data_in>=NUM_CH).
  - Otherwise hold.
- write_enb, combinational:
  - Bit fifo_addr is set iff write_enb_reg=1 and addr_err=0.
  - Otherwise all zero. Never more than one bit set.
- fifo_full, combinational: full[fifo_addr] if in range, else 0.
- vld_out[i] = ~empty[i], combinational.
- Timeout register:
  - If timeout_ld: timeout_reg<=timeout_val, and all counters<=0 on the same edge.
  - soft_reset is not asserted on a load edge.
- Per-channel counter i, evaluated per edge in this priority order:
  1. reset, or timeout_ld, or timeout_reg==0 -> cnt<=0, soft_reset[i]<=0
  2. empty[i]=1 -> cnt<=0, soft_reset[i]<=0
  3. read_enb[i]=1 -> cnt<=0, soft_reset[i]<=0
  4. cnt==timeout_reg-1 -> soft_reset[i]<=1, cnt<=0
  5. else -> cnt<=cnt+1, soft_reset[i]<=0
- Resulting timing and width rules:
  - soft_reset[i] rises in the cycle after the timeout_reg-th consecutive edge with valid and no read.
  - The pulse lasts exactly 1 cycle; the count restarts, so repeated stalls pulse every timeout_reg cycles.
  - timeout_reg=1 gives a pulse on every qualifying edge.
  - Counter arithmetic is CNT_W-bit and cannot wrap, because the compare precedes the increment.
- Sticky status:
  - sft_rst_status[i] is set on the edge where soft_reset[i] is set.
  - It is cleared by status_clr[i]=1. If set and clear occur on the same edge, set wins.
- Channels are fully independent; simultaneous timeouts on several channels all pulse.

Decomposition:
- Shared package router_pkg:
  - ROUTER_NUM_CH, ROUTER_ADDR_W, ROUTER_DEF_TIMEOUT constants.
  - A function checking 2**ADDR_W>=NUM_CH (elaboration assertion).
- One natural sub-module: router_sft_rst_timer, a single-channel counter plus pulse plus sticky status, instantiated NUM_CH times with a generate loop.

Test Plan:
1. Reset, then detect_add with data_in=2, then write_enb_reg=1 -> write_enb=3'b100, addr_err=0. Then full[2]=1 -> fifo_full=1.
2. detect_add with data_in=3 (NUM_CH=3), write_enb_reg=1 -> addr_err=1, write_enb=3'b000, fifo_full=0. Then a new detect_add with data_in=0 -> addr_err=0, write_enb=3'b001.
3. Default timeout: empty[1]=0 and read_enb[1]=0 held -> soft_reset[1] high for one cycle after the 30th edge, again after the 60th; sft_rst_status[1]=1. A read_enb[1] pulse at edge 15 restarts the count, so the pulse lands at edge 45.
4. timeout_ld with timeout_val=4 mid-count (count at 20) -> counters cleared, next pulse 4 edges after the load. Then timeout_val=0 -> no pulses for 100 stalled cycles.
5. status_clr[0]=1 on the same edge as a channel-0 timeout -> status stays 1. status_clr[0]=1 on a later edge -> status 0.
6. Assert reset at count 25 with detect_add active -> all outputs/status 0, fifo_addr=0, timeout_reg=30. After deassertion, a full 30-cycle stall is required before the next pulse.
